// File: rtl/ripple_carry_adder.sv
// Parametric ripple-carry adder with a registered {carry-out, sum} result.
// Operands and carry-in arrive on sw; the result is shown on ledr.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2*WIDTH:0]   sw,
  output logic [WIDTH:0]     ledr
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   c;

  assign b    = sw[WIDTH-1:0];
  assign a    = sw[2*WIDTH-1:WIDTH];
  assign c[0] = sw[2*WIDTH];

  // Carry ripples cell-to-cell; the chain from c[0] to c[WIDTH] is the critical path.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ledr <= '0;
    end else begin
      ledr <= {c[WIDTH], s};
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder (WIDTH=4): expected results are
// queued when sw is driven and compared one edge later.

module tb_ripple_carry_adder;

  localparam int WIDTH = 4;

  typedef struct {
    string          tag;
    logic [WIDTH:0] exp;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [2*WIDTH:0] sw = '0;
  logic [WIDTH:0]   ledr;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  ripple_carry_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw),
    .ledr  (ledr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue its expected result.
  task automatic drive(input string tag, input logic r, input int a, input int b, input int ci);
    exp_t e;
    int   sum;
    @(negedge clk);
    reset = r;
    sw    = {ci[0], a[WIDTH-1:0], b[WIDTH-1:0]};
    sum   = a + b + ci;
    e.tag = tag;
    e.exp = r ? '0 : sum[WIDTH:0];
    q.push_back(e);
  endtask

  task automatic drive_raw(input string tag, input logic r, input logic [2*WIDTH:0] v);
    exp_t e;
    @(negedge clk);
    reset = r;
    sw    = v;
    e.tag = tag;
    e.exp = '0;
    q.push_back(e);
  endtask

  // Monitor: compare ledr just after each rising edge that has a pending result.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, {27'd0, ledr}, {27'd0, e.exp});
    end
  end

  initial begin
    // Reset held across several edges with all switches high.
    drive_raw("reset0", 1'b1, 9'h1FF);
    drive_raw("reset1", 1'b1, 9'h1FF);
    drive_raw("reset2", 1'b1, 9'h1FF);

    drive("zero",      1'b0, 0,  0,  0);
    drive("pass_b",    1'b0, 0,  5,  0);
    drive("ripple_b1", 1'b0, 15, 1,  0);
    drive("ripple_ci", 1'b0, 15, 0,  1);
    drive("max",       1'b0, 15, 15, 1);

    for (int ci = 0; ci < 2; ci++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          drive($sformatf("sweep_a%0d_b%0d_c%0d", a, b, ci), 1'b0, a, b, ci);

    drive("mid_pre",   1'b0, 9, 7, 0);
    drive("mid_rst",   1'b1, 9, 7, 0);
    drive("mid_post",  1'b0, 9, 7, 0);

    drive("b2b_first",  1'b0, 3, 4, 0);
    drive("b2b_second", 1'b0, 8, 8, 1);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    check("drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
